// File: rtl/dac_sample_scheduler.sv
// Sample-rate scheduler for a delta-sigma DAC: it paces samples with a sample tick, applies a click-free gain ramp, and counts underruns.
// Define DAC_SCHED_FIFO_EN to get a 4-entry input FIFO; without it the buffer is a single holding register.
module dac_sample_scheduler #(
  parameter int CLKS_PER_SAMPLE = 2083,
  parameter int RAMP_STEP       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] in_sample,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] dac_sample,
  output logic        sample_tick,
  output logic        running,
  output logic        underrun,
  output logic [7:0]  underrun_count
);

  localparam int CW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [9:0] STEP = 10'(RAMP_STEP);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;

  state_t      state, state_nx, eff_state;
  logic [8:0]  gain, gain_nx;
  logic [9:0]  up_sum;
  logic [8:0]  down_val;
  logic [CW-1:0] cnt;
  logic        tick, tick_d;
  logic        flush, push, pop, empty, full;
  logic [15:0] head, cur_sample;
  logic signed [24:0] prod;

  assign tick        = (cnt == CW'(CLKS_PER_SAMPLE - 1));
  assign sample_tick = tick;
  assign running     = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

  assign up_sum   = {1'b0, gain} + STEP;
  assign down_val = ({1'b0, gain} <= STEP) ? 9'd0 : 9'({1'b0, gain} - STEP);

  // The enable request is resolved first; a coincident tick then follows the new state's gain rule.
  always_comb begin
    eff_state = state;
    state_nx  = state;
    gain_nx   = gain;
    flush     = 1'b0;
    case (state)
      IDLE:          if (enable)  eff_state = RAMP_UP;
      RAMP_UP, RUN:  if (!enable) eff_state = RAMP_DOWN;
      RAMP_DOWN:     if (enable)  eff_state = RAMP_UP;
      default:       eff_state = IDLE;
    endcase
    state_nx = eff_state;
    if (tick) begin
      case (eff_state)
        RAMP_UP: begin
          gain_nx = (up_sum >= 10'd256) ? 9'd256 : up_sum[8:0];
          if (up_sum >= 10'd256) state_nx = RUN;
        end
        RUN: gain_nx = 9'd256;
        RAMP_DOWN: begin
          gain_nx = down_val;
          if (down_val == 9'd0) begin
            state_nx = IDLE;
            flush    = 1'b1;
          end
        end
        default: gain_nx = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gain  <= '0;
    end else begin
      state <= state_nx;
      gain  <= gain_nx;
    end
  end

  assign in_ready = (state != IDLE) && !full;
  assign push     = in_valid && in_ready;
  assign pop      = tick && (eff_state != IDLE) && !empty;
  assign underrun = tick && (eff_state == RUN) && empty;

`ifdef DAC_SCHED_FIFO_EN
  logic [15:0] mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;

  assign empty = (count == 3'd0);
  assign full  = (count == 3'd4);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_sample;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end
`else
  logic        hold_valid;
  logic [15:0] hold_data;

  assign empty = !hold_valid;
  assign full  = hold_valid;
  assign head  = hold_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (flush) begin
      hold_valid <= 1'b0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_data  <= in_sample;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  assign prod = $signed({{9{cur_sample[15]}}, cur_sample}) * $signed({16'd0, gain});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sample     <= '0;
      tick_d         <= 1'b0;
      dac_sample     <= '0;
      underrun_count <= '0;
    end else begin
      tick_d <= tick;
      if (pop) cur_sample <= head;
      if (state == IDLE)  dac_sample <= '0;
      else if (tick_d)    dac_sample <= 16'(prod >>> 8);
      if (underrun && underrun_count != 8'hFF) underrun_count <= underrun_count + 8'd1;
    end
  end

endmodule
